// File: rtl/isr_pkg.sv
// Shared definitions for the instruction-register prefetch queue.
package isr_pkg;

  localparam int ISR_WIDTH_DEFAULT  = 16;
  localparam int ISRQ_DEPTH_DEFAULT = 4;

  typedef logic [ISR_WIDTH_DEFAULT-1:0] isr_word_t;

  // Pointer width for a queue of the given depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/isr_fifo.sv
// DEPTH-entry register queue with wrapping pointers, occupancy count and
// full/empty flags; clear may be combined with push to seed the first entry.
module isr_fifo
  import isr_pkg::*;
#(
  parameter int WIDTH = ISR_WIDTH_DEFAULT,
  parameter int DEPTH = ISRQ_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    wr_addr;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] entries [DEPTH];

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    wr_addr     = wr_ptr_reg;
    if (clear) begin
      // A push alongside clear lands in slot 0 of the emptied queue.
      rd_ptr_next = '0;
      wr_addr     = '0;
      wr_ptr_next = PW'(push);
      count_next  = CW'(push);
    end else begin
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      wr_ptr_next = wr_ptr_reg + PW'(push);
      count_next  = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_addr == PW'(gi))) begin
          entry_reg <= wr_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign head  = entries[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/isr_prefetch_queue.sv
// Prefetching instruction register: queue of fetched words feeding one
// current-instruction slot. Optional same-edge bypass via ISRQ_BYPASS_EN.
module isr_prefetch_queue
  import isr_pkg::*;
#(
  parameter int WIDTH = ISR_WIDTH_DEFAULT,
  parameter int DEPTH = ISRQ_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] m_bus,
  input  logic             MIS,
  input  logic             ISR_take,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] ISR_out,
  output logic             ISR_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] isr_out_reg, isr_out_next;
  logic             isr_valid_reg, isr_valid_next;
  logic             overflow_reg, overflow_next;

  logic             fifo_clear, fifo_push, fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic             loadable;
  logic             bypass_hit;

  isr_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk    (CLK),
    .clr_n  (CLR),
    .clear  (fifo_clear),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_data(m_bus),
    .head   (fifo_head),
    .count  (count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign loadable = !isr_valid_reg || ISR_take;

`ifdef ISRQ_BYPASS_EN
  assign bypass_hit = loadable && fifo_empty && MIS;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    isr_out_next   = isr_out_reg;
    isr_valid_next = isr_valid_reg;
    overflow_next  = overflow_reg;
    fifo_clear     = 1'b0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    if (FLUSH) begin
      fifo_clear     = 1'b1;
      isr_valid_next = 1'b0;
      overflow_next  = 1'b0;
`ifdef ISRQ_BYPASS_EN
      if (MIS) begin
        isr_out_next   = m_bus;
        isr_valid_next = 1'b1;
      end
`else
      fifo_push = MIS;
`endif
    end else begin
      if (loadable && !fifo_empty) begin
        fifo_pop       = 1'b1;
        isr_out_next   = fifo_head;
        isr_valid_next = 1'b1;
      end else if (bypass_hit) begin
        isr_out_next   = m_bus;
        isr_valid_next = 1'b1;
      end else if (ISR_take) begin
        // Consumed with nothing behind it: the slot goes empty, data is kept.
        isr_valid_next = 1'b0;
      end
      if (MIS && !bypass_hit) begin
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
        end else begin
          overflow_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      isr_out_reg   <= '0;
      isr_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      isr_out_reg   <= isr_out_next;
      isr_valid_reg <= isr_valid_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign ISR_out   = isr_out_reg;
  assign ISR_valid = isr_valid_reg;
  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_isr_prefetch_queue.sv
// Bench for isr_prefetch_queue: directed table, wrap-around stream and a
// randomized run against a queue-based reference model.
module tb_isr_prefetch_queue;
  import isr_pkg::*;

  localparam int DEPTH = ISRQ_DEPTH_DEFAULT;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            CLK = 1'b0;
  logic            CLR = 1'b0;
  isr_word_t       m_bus = '0;
  logic            MIS = 1'b0;
  logic            ISR_take = 1'b0;
  logic            FLUSH = 1'b0;
  isr_word_t       ISR_out;
  logic            ISR_valid;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state
  isr_word_t mq[$];
  isr_word_t m_out   = '0;
  logic      m_valid = 1'b0;
  logic      m_ovf   = 1'b0;

  isr_prefetch_queue #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .CLR(CLR), .m_bus(m_bus), .MIS(MIS), .ISR_take(ISR_take),
    .FLUSH(FLUSH), .ISR_out(ISR_out), .ISR_valid(ISR_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic      clr;
    logic      mis;
    isr_word_t data;
    logic      take;
    logic      flush;
    isr_word_t eout;
    logic      ev;
    int        ec;
    logic      eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, input logic mis, input isr_word_t data,
                              input logic take, input logic flush, input isr_word_t eout,
                              input logic ev, input int ec, input logic eovf);
    vec_t v;
    v.clr = clr; v.mis = mis; v.data = data; v.take = take; v.flush = flush;
    v.eout = eout; v.ev = ev; v.ec = ec; v.eovf = eovf;
    return v;
  endfunction

  // Behaviour at one clock edge, stated directly from the queue rules.
  task automatic model_step(input logic clr, input logic mis, input isr_word_t data,
                            input logic take, input logic flush);
    int  old_size;
    bit  popped, bypassed, can_load;
    if (!clr) begin
      mq.delete(); m_out = '0; m_valid = 0; m_ovf = 0;
    end else if (flush) begin
      mq.delete(); m_valid = 0; m_ovf = 0;
      if (mis) begin
`ifdef ISRQ_BYPASS_EN
        m_out = data; m_valid = 1;
`else
        mq.push_back(data);
`endif
      end
    end else begin
      old_size = mq.size();
      can_load = !m_valid || take;
      popped = 0; bypassed = 0;
      if (can_load && old_size > 0) begin
        m_out = mq.pop_front(); m_valid = 1; popped = 1;
      end else if (can_load && mis && `ifdef ISRQ_BYPASS_EN 1 `else 0 `endif) begin
        m_out = data; m_valid = 1; bypassed = 1;
      end else if (can_load) begin
        m_valid = 0;
      end
      if (mis && !bypassed) begin
        if (old_size < DEPTH || popped) mq.push_back(data);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input logic clr, input logic mis, input isr_word_t data,
                       input logic take, input logic flush);
    CLR = clr; MIS = mis; m_bus = data; ISR_take = take; FLUSH = flush;
    @(posedge CLK);
    model_step(clr, mis, data, take, flush);
    #1;
    cyc++;
    $display("cyc %0d clr=%b mis=%b data=%h take=%b flush=%b -> out=%h v=%b cnt=%0d full=%b empty=%b ovf=%b",
             cyc, clr, mis, data, take, flush, ISR_out, ISR_valid, count, full, empty, overflow);
  endtask

  task automatic chk_all(input string tag, input isr_word_t eout, input logic ev,
                         input int ec, input logic eovf);
    chk({tag, ".ISR_out"},   32'(ISR_out),   32'(eout));
    chk({tag, ".ISR_valid"}, 32'(ISR_valid), 32'(ev));
    chk({tag, ".count"},     32'(count),     32'(ec));
    chk({tag, ".full"},      32'(full),      32'(ec == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(ec == 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(eovf));
  endtask

  initial begin
`ifndef ISRQ_BYPASS_EN
    // reset with every other input active, then idle
    tbl.push_back(mk(0, 1, 16'hFFFF, 1, 1, 16'h0000, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
    // basic fetch
    tbl.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h5678, 0, 0, 16'h1234, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h9ABC, 0, 0, 16'h1234, 1, 2, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h5678, 1, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h9ABC, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h9ABC, 0, 0, 0));
    // overflow: fill to DEPTH behind a valid slot, fifth word dropped
    tbl.push_back(mk(1, 1, 16'h1111, 0, 0, 16'h9ABC, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h1111, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h2001, 0, 0, 16'h1111, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h2002, 0, 0, 16'h1111, 1, 2, 0));
    tbl.push_back(mk(1, 1, 16'h2003, 0, 0, 16'h1111, 1, 3, 0));
    tbl.push_back(mk(1, 1, 16'h2004, 0, 0, 16'h1111, 1, 4, 0));
    tbl.push_back(mk(1, 1, 16'h2005, 0, 0, 16'h1111, 1, 4, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2001, 1, 3, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2002, 1, 2, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2003, 1, 1, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2004, 1, 0, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2004, 0, 0, 1));
    // plain flush clears the sticky flag
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h2004, 0, 0, 0));
    // full queue with a take on the fifth push: word accepted
    tbl.push_back(mk(1, 1, 16'h3000, 0, 0, 16'h2004, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h3000, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h3001, 0, 0, 16'h3000, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h3002, 0, 0, 16'h3000, 1, 2, 0));
    tbl.push_back(mk(1, 1, 16'h3003, 0, 0, 16'h3000, 1, 3, 0));
    tbl.push_back(mk(1, 1, 16'h3004, 0, 0, 16'h3000, 1, 4, 0));
    tbl.push_back(mk(1, 1, 16'h3005, 1, 0, 16'h3001, 1, 4, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h3002, 1, 3, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h3003, 1, 2, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h3004, 1, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h3005, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h3005, 0, 0, 0));
    // flush with branch-target fetch at count=3
    tbl.push_back(mk(1, 1, 16'h4001, 0, 0, 16'h3005, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h4002, 0, 0, 16'h4001, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h4003, 0, 0, 16'h4001, 1, 2, 0));
    tbl.push_back(mk(1, 1, 16'h4004, 0, 0, 16'h4001, 1, 3, 0));
    tbl.push_back(mk(1, 1, 16'hBEEF, 0, 1, 16'h4001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0));
    // reset mid-stream with count=3
    tbl.push_back(mk(1, 1, 16'h5001, 0, 0, 16'hBEEF, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h5002, 0, 0, 16'hBEEF, 1, 2, 0));
    tbl.push_back(mk(1, 1, 16'h5003, 0, 0, 16'hBEEF, 1, 3, 0));
    tbl.push_back(mk(0, 1, 16'h5004, 1, 0, 16'h0000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].clr, tbl[i].mis, tbl[i].data, tbl[i].take, tbl[i].flush);
      chk_all($sformatf("tbl%0d", i), tbl[i].eout, tbl[i].ev, tbl[i].ec, tbl[i].eovf);
    end

    // wrap-around: ten words streamed with a take every cycle
    for (int i = 0; i < 10; i++) begin
      apply(1, 1, isr_word_t'(16'h7000 + i), 1, 0);
      if (i == 0) chk_all("wrap0", 16'h0000, 0, 1, 0);
      else        chk_all($sformatf("wrap%0d", i), isr_word_t'(16'h7000 + i - 1), 1, 1, 0);
    end
    apply(1, 0, '0, 1, 0);
    chk_all("wrap_tail", 16'h7009, 1, 0, 0);
    apply(1, 0, '0, 1, 0);
    chk_all("wrap_drain", 16'h7009, 0, 0, 0);
`endif

    // randomized run against the reference model
    apply(0, 0, '0, 0, 0);
    chk_all("rand_reset", '0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic      r_clr, r_mis, r_take, r_flush;
      isr_word_t r_data;
      r_clr   = ($urandom_range(0, 59) != 0);
      r_flush = ($urandom_range(0, 19) == 0);
      r_mis   = ($urandom_range(0, 2) != 0);
      r_take  = ($urandom_range(0, 1) == 1);
      r_data  = isr_word_t'($urandom);
      apply(r_clr, r_mis, r_data, r_take, r_flush);
      chk_all($sformatf("rand%0d", i), m_out, m_valid, mq.size(), m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
